// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART byte-stream to memory-interface bridge.
// Command and status byte encodings match the host tool's wire protocol.
package uart_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_EXEC,
    ST_RESP_STAT,
    ST_RESP_DATA
  } state_e;

  localparam logic [7:0] CMD_WRITE    = 8'h57;
  localparam logic [7:0] CMD_READ     = 8'h52;
  localparam logic [7:0] STAT_OK_BASE = 8'hA0;
  localparam logic [7:0] STAT_BADCMD  = 8'hEE;

  // Status byte carries the slave response in its two low bits.
  function automatic logic [7:0] make_status(input logic [1:0] resp);
    return STAT_OK_BASE | {6'b000000, resp};
  endfunction

endpackage

// File: rtl/uart_mem_bridge.sv
// Decodes write/read command frames from a received byte stream, issues one access on the
// simple memory interface and returns a status byte (plus read data) as a byte stream.
module uart_mem_bridge
  import uart_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_waddr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_wstrb_o,
  input  logic [1:0]            mem_wresp_i,
  output logic                  mem_re_o,
  output logic [ADDR_WIDTH-1:0] mem_raddr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic [1:0]            mem_rresp_i,
  output logic                  busy_o,
  output logic                  timeout_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                  state_reg;
  logic                    is_write_reg;
  logic                    is_read_reg;
  logic [1:0]              idx_reg;
  logic [31:0]             addr_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;
  logic [CNT_W-1:0]        tmo_cnt_reg;
  logic                    rx_ready_reg;
  logic [7:0]              tx_data_reg;
  logic                    tx_valid_reg;
  logic                    mem_we_reg;
  logic                    mem_re_reg;
  logic [3:0]              mem_wstrb_reg;
  logic                    timeout_reg;

  logic rx_accept;
  logic tx_done;

  assign rx_accept = rx_valid_i & rx_ready_reg;
  assign tx_done   = tx_valid_reg & tx_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg     <= ST_IDLE;
      is_write_reg  <= 1'b0;
      is_read_reg   <= 1'b0;
      idx_reg       <= 2'd0;
      addr_reg      <= '0;
      data_reg      <= '0;
      rdata_reg     <= '0;
      tmo_cnt_reg   <= '0;
      rx_ready_reg  <= 1'b0;
      tx_data_reg   <= 8'h00;
      tx_valid_reg  <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_re_reg    <= 1'b0;
      mem_wstrb_reg <= 4'h0;
      timeout_reg   <= 1'b0;
    end else begin
      mem_we_reg    <= 1'b0;
      mem_re_reg    <= 1'b0;
      mem_wstrb_reg <= 4'h0;
      timeout_reg   <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          rx_ready_reg <= 1'b1;
          tmo_cnt_reg  <= '0;
          idx_reg      <= 2'd0;
          if (rx_accept) begin
            if (rx_data_i == CMD_WRITE || rx_data_i == CMD_READ) begin
              is_write_reg <= (rx_data_i == CMD_WRITE);
              is_read_reg  <= (rx_data_i == CMD_READ);
              state_reg    <= ST_ADDR;
            end else begin
              // Unknown command: answer with an error status and skip the memory access.
              is_write_reg <= 1'b0;
              is_read_reg  <= 1'b0;
              tx_data_reg  <= STAT_BADCMD;
              tx_valid_reg <= 1'b1;
              rx_ready_reg <= 1'b0;
              state_reg    <= ST_RESP_STAT;
            end
          end
        end

        ST_ADDR, ST_DATA: begin
          if (rx_accept) begin
            tmo_cnt_reg <= '0;
            idx_reg     <= idx_reg + 2'd1;
            if (state_reg == ST_ADDR) begin
              addr_reg <= {rx_data_i, addr_reg[31:8]};
            end else begin
              data_reg <= {rx_data_i, data_reg[DATA_WIDTH-1:8]};
            end
            if (idx_reg == 2'd3) begin
              if (state_reg == ST_ADDR && is_write_reg) begin
                state_reg <= ST_DATA;
              end else begin
                state_reg     <= ST_EXEC;
                rx_ready_reg  <= 1'b0;
                mem_we_reg    <= is_write_reg;
                mem_re_reg    <= is_read_reg;
                mem_wstrb_reg <= is_write_reg ? 4'hF : 4'h0;
              end
            end
          end else if (tmo_cnt_reg == TMO_LAST) begin
            // Host stalled mid-frame: drop it silently and resynchronise on the next command byte.
            state_reg   <= ST_IDLE;
            timeout_reg <= 1'b1;
            tmo_cnt_reg <= '0;
            idx_reg     <= 2'd0;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
          end
        end

        ST_EXEC: begin
          tx_valid_reg <= 1'b1;
          state_reg    <= ST_RESP_STAT;
          if (is_write_reg) begin
            tx_data_reg <= make_status(mem_wresp_i);
          end else begin
            tx_data_reg <= make_status(mem_rresp_i);
            rdata_reg   <= mem_rdata_i;
          end
        end

        ST_RESP_STAT: begin
          if (tx_done) begin
            if (is_read_reg) begin
              tx_data_reg <= rdata_reg[7:0];
              rdata_reg   <= rdata_reg >> 8;
              idx_reg     <= 2'd0;
              state_reg   <= ST_RESP_DATA;
            end else begin
              tx_valid_reg <= 1'b0;
              rx_ready_reg <= 1'b1;
              state_reg    <= ST_IDLE;
            end
          end
        end

        ST_RESP_DATA: begin
          if (tx_done) begin
            if (idx_reg == 2'd3) begin
              tx_valid_reg <= 1'b0;
              rx_ready_reg <= 1'b1;
              state_reg    <= ST_IDLE;
            end else begin
              tx_data_reg <= rdata_reg[7:0];
              rdata_reg   <= rdata_reg >> 8;
              idx_reg     <= idx_reg + 2'd1;
            end
          end
        end

        default: begin
          state_reg    <= ST_IDLE;
          tx_valid_reg <= 1'b0;
          rx_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  // Wire addresses are always 4 bytes; bits above the bus width are simply dropped.
  generate
    if (ADDR_WIDTH < 32) begin : g_addr_trim
      logic addr_hi_unused;
      assign addr_hi_unused = ^addr_reg[31:ADDR_WIDTH];
    end
  endgenerate

  assign rx_ready_o  = rx_ready_reg;
  assign tx_data_o   = tx_data_reg;
  assign tx_valid_o  = tx_valid_reg;
  assign mem_we_o    = mem_we_reg;
  assign mem_waddr_o = addr_reg[ADDR_WIDTH-1:0];
  assign mem_wdata_o = data_reg;
  assign mem_wstrb_o = mem_wstrb_reg;
  assign mem_re_o    = mem_re_reg;
  assign mem_raddr_o = addr_reg[ADDR_WIDTH-1:0];
  assign busy_o      = (state_reg != ST_IDLE);
  assign timeout_o   = timeout_reg;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed bench for uart_mem_bridge: command frames in, memory strobes and response bytes out.
module tb_uart_mem_bridge;

  localparam int AW  = 6;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [1:0]    mem_wresp = 2'b00;
  logic          mem_re;
  logic [AW-1:0] mem_raddr;
  logic [31:0]   mem_rdata = 32'h0;
  logic [1:0]    mem_rresp = 2'b00;
  logic          busy;
  logic          timeout;

  always #5 clk = ~clk;

  uart_mem_bridge #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .rx_data_i(rx_data),
    .rx_valid_i(rx_valid),
    .rx_ready_o(rx_ready),
    .tx_data_o(tx_data),
    .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready),
    .mem_we_o(mem_we),
    .mem_waddr_o(mem_waddr),
    .mem_wdata_o(mem_wdata),
    .mem_wstrb_o(mem_wstrb),
    .mem_wresp_i(mem_wresp),
    .mem_re_o(mem_re),
    .mem_raddr_o(mem_raddr),
    .mem_rdata_i(mem_rdata),
    .mem_rresp_i(mem_rresp),
    .busy_o(busy),
    .timeout_o(timeout)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor, sampled on the falling edge.
  logic [7:0]    txq[$];
  int            we_cnt = 0, re_cnt = 0, tmo_cnt = 0;
  int            we_cyc = 0, re_cyc = 0, tmo_cyc = 0, rise_cyc = 0;
  logic [AW-1:0] last_waddr = '0, last_raddr = '0;
  logic [31:0]   last_wdata = '0;
  logic [3:0]    last_wstrb = '0;
  logic          prev_valid = 1'b0;

  always @(negedge clk) begin
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (tx_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = tx_valid;
    if (mem_we) begin
      we_cnt++;
      we_cyc = cyc;
      last_waddr = mem_waddr;
      last_wdata = mem_wdata;
      last_wstrb = mem_wstrb;
    end
    if (mem_re) begin
      re_cnt++;
      re_cyc = cyc;
      last_raddr = mem_raddr;
    end
    if (timeout) begin
      tmo_cnt++;
      tmo_cyc = cyc;
    end
  end

  int tx_base = 0, we_base = 0, re_base = 0, tmo_base = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    tx_base  = txq.size();
    we_base  = we_cnt;
    re_base  = re_cnt;
    tmo_base = tmo_cnt;
  endtask

  function automatic int n_tx();
    return txq.size() - tx_base;
  endfunction

  function automatic logic [31:0] txb(input int i);
    if (tx_base + i < txq.size()) return {24'h0, txq[tx_base + i]};
    return 32'hDEAD0000;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("rx_ready_wait", {31'h0, rx_ready}, 32'h1);
    @(posedge clk);
    #1;
    last_acc = cyc;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_write(input logic [31:0] addr, input logic [31:0] data);
    $display("write addr=%08h data=%08h wresp=%0d", addr, data, mem_wresp);
    send_byte(8'h57);
    send_word(addr);
    send_word(data);
  endtask

  task automatic send_read(input logic [31:0] addr);
    $display("read  addr=%08h rdata=%08h rresp=%0d", addr, mem_rdata, mem_rresp);
    send_byte(8'h52);
    send_word(addr);
  endtask

  task automatic wait_tx(input int n);
    int k = 0;
    while (n_tx() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_tx_valid();
    int k = 0;
    while (!tx_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check_read_resp(input string tag, input logic [7:0] stat, input logic [31:0] d);
    check({tag, "_count"}, n_tx(), 5);
    check({tag, "_stat"}, txb(0), {24'h0, stat});
    for (int i = 0; i < 4; i++) check({tag, "_data"}, txb(i + 1), {24'h0, d[8*i +: 8]});
  endtask

  logic [7:0] held;
  logic       stable, rxr_low;
  int         k;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {26'h0, rx_ready, tx_valid, busy, mem_we, mem_re, timeout}, 32'h0);
    check("rst_txdata", {20'h0, tx_data, mem_wstrb}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready", {31'h0, rx_ready}, 32'h1);

    // Write, OKAY
    mark();
    mem_wresp = 2'b00;
    send_write(32'h00000004, 32'hDEADBEEF);
    wait_tx(1);
    check("wr_we_count", we_cnt - we_base, 1);
    check("wr_re_count", re_cnt - re_base, 0);
    check("wr_waddr", {26'h0, last_waddr}, 32'h04);
    check("wr_wdata", last_wdata, 32'hDEADBEEF);
    check("wr_wstrb", {28'h0, last_wstrb}, 32'hF);
    check("wr_strobe_lat", we_cyc, last_acc);
    check("wr_tx_lat", rise_cyc, last_acc + 1);
    check("wr_count", n_tx(), 1);
    check("wr_stat", txb(0), 32'hA0);
    check("wr_idle", {31'h0, busy}, 32'h0);

    // Read, OKAY
    mark();
    mem_rdata = 32'h12345678;
    mem_rresp = 2'b00;
    send_read(32'h00000008);
    wait_tx(5);
    check("rd_re_count", re_cnt - re_base, 1);
    check("rd_we_count", we_cnt - we_base, 0);
    check("rd_raddr", {26'h0, last_raddr}, 32'h08);
    check("rd_strobe_lat", re_cyc, last_acc);
    check("rd_tx_lat", rise_cyc, last_acc + 1);
    check_read_resp("rd", 8'hA0, 32'h12345678);

    // Read with SLVERR-style response
    mark();
    mem_rdata = 32'hCAFEF00D;
    mem_rresp = 2'b10;
    send_read(32'h0000000C);
    wait_tx(5);
    check_read_resp("rd_err", 8'hA2, 32'hCAFEF00D);

    // Write with error response and address bits above the bus width
    mark();
    mem_wresp = 2'b11;
    send_write(32'hFFFFFF7F, 32'h0BADF00D);
    wait_tx(1);
    check("wr_err_waddr", {26'h0, last_waddr}, 32'h3F);
    check("wr_err_wdata", last_wdata, 32'h0BADF00D);
    check("wr_err_count", n_tx(), 1);
    check("wr_err_stat", txb(0), 32'hA3);
    mem_wresp = 2'b00;

    // Unknown command byte, then a normal frame
    mark();
    $display("bad command byte 33");
    send_byte(8'h33);
    wait_tx(1);
    check("bad_count", n_tx(), 1);
    check("bad_stat", txb(0), 32'hEE);
    check("bad_strobes", (we_cnt - we_base) + (re_cnt - re_base), 0);
    mark();
    send_write(32'h00000010, 32'h11223344);
    wait_tx(1);
    check("after_bad_we", we_cnt - we_base, 1);
    check("after_bad_wdata", last_wdata, 32'h11223344);
    check("after_bad_stat", txb(0), 32'hA0);

    // Timeout: stall after one address byte
    mark();
    $display("partial frame 57 01, then stall");
    send_byte(8'h57);
    send_byte(8'h01);
    k = 0;
    while (tmo_cnt == tmo_base && k < 40) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check("tmo_pulses", tmo_cnt - tmo_base, 1);
    check("tmo_lat", tmo_cyc, last_acc + TMO);
    check("tmo_busy", {31'h0, busy}, 32'h0);
    check("tmo_strobes", (we_cnt - we_base) + (re_cnt - re_base), 0);
    check("tmo_tx", n_tx(), 0);

    // Byte arriving on the last allowed cycle wins over the timeout
    mark();
    mem_rdata = 32'h00000000;
    mem_rresp = 2'b00;
    $display("read addr=00000010 with late second byte");
    send_byte(8'h52);
    send_byte(8'h10);
    repeat (TMO - 1) @(negedge clk);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_tx(5);
    check("late_tmo", tmo_cnt - tmo_base, 0);
    check("late_re", re_cnt - re_base, 1);
    check("late_raddr", {26'h0, last_raddr}, 32'h10);
    check("late_stat", txb(0), 32'hA0);

    // Back-pressure on the response stream
    mark();
    mem_rdata = 32'hA5A55A5A;
    tx_ready = 1'b0;
    send_read(32'h00000014);
    wait_tx_valid();
    check("bp_valid", {31'h0, tx_valid}, 32'h1);
    held = tx_data;
    stable = 1'b1;
    rxr_low = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (tx_data !== held || !tx_valid) stable = 1'b0;
      if (rx_ready) rxr_low = 1'b0;
    end
    check("bp_held", {24'h0, held}, 32'hA0);
    check("bp_stable", {31'h0, stable}, 32'h1);
    check("bp_rx_blocked", {31'h0, rxr_low}, 32'h1);
    check("bp_no_tx", n_tx(), 0);
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    wait_tx(5);
    check_read_resp("bp", 8'hA0, 32'hA5A55A5A);

    // Reset in the middle of a frame
    mark();
    $display("reset mid-frame after 57 04 00");
    send_byte(8'h57);
    send_byte(8'h04);
    send_byte(8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_outputs", {26'h0, rx_ready, tx_valid, busy, mem_we, mem_re, timeout}, 32'h0);
    check("midrst_addr", {20'h0, mem_waddr, mem_raddr}, 32'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_strobes", (we_cnt - we_base) + (re_cnt - re_base), 0);
    check("midrst_tmo", tmo_cnt - tmo_base, 0);
    check("midrst_tx", n_tx(), 0);
    mark();
    send_write(32'h00000020, 32'h01020304);
    wait_tx(1);
    check("midrst_recover_we", we_cnt - we_base, 1);
    check("midrst_recover_addr", {26'h0, last_waddr}, 32'h20);
    check("midrst_recover_stat", txb(0), 32'hA0);

    // Reset while a response byte is pending
    mark();
    tx_ready = 1'b0;
    mem_rdata = 32'h55667788;
    send_read(32'h00000024);
    wait_tx_valid();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rsprst_valid", {30'h0, tx_valid, busy}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("rsprst_dropped", n_tx(), 0);
    check("rsprst_ready", {31'h0, rx_ready}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1);
  end

endmodule
